// File: rtl/iir_eq_slicer_pkg.sv
// Shared constants, default coefficients and FSM state type for the IIR equaliser.
package eq_pkg;

  localparam int unsigned MAX_ORDER = 8;

  // Tap k is stored at index k-1; taps beyond the second default to zero.
  localparam real DEF_A [MAX_ORDER] = '{1.424, -0.5001, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0};
  localparam real DEF_B [MAX_ORDER] = '{7.264, -7.188, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0};

  typedef enum logic {
    WARMUP,
    RUN
  } eq_state_e;

endpackage

// File: rtl/eq_slicer.sv
// Hysteresis slicer: registered decision bit with a dead band centred on THRESH.
module eq_slicer #(
  parameter real THRESH = 0.49427,
  parameter real HYST   = 0.0
) (
  input  logic clk,
  input  logic rst,
  input  real  value_i,
  output logic bit_o
);

  logic bit_q, bit_d;

  // Set above the upper band edge, clear below the lower edge, otherwise hold.
  always_comb begin
    bit_d = bit_q;
    if (value_i >= THRESH + HYST / 2.0) begin
      bit_d = 1'b1;
    end else if (value_i < THRESH - HYST / 2.0) begin
      bit_d = 1'b0;
    end
  end

  // Decision register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/iir_eq_slicer.sv
// IIR equaliser (feedback + feed-forward taps, no b0 term) with output clamp,
// shadow/active coefficient banks, warm-up qualifier and hysteresis slicer.
module iir_eq_slicer #(
  parameter  int unsigned ORDER     = 2,
  parameter  int unsigned WARMUP    = 2,
  parameter  real         THRESH    = 0.49427,
  parameter  real         HYST      = 0.0,
  parameter  real         SAT_LIMIT = 16.0,
  localparam int unsigned IDX_W     = $clog2(ORDER) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  real              eq_in,
  input  logic             bypass,
  input  logic             coef_wr,
  input  logic             coef_sel,
  input  logic [IDX_W-1:0] coef_idx,
  input  real              coef_data,
  input  logic             coef_commit,
  output real              eq_y,
  output logic             eq_bit,
  output logic             eq_valid,
  output logic             sat_flag
);

  import eq_pkg::*;

  real a_q   [MAX_ORDER];
  real b_q   [MAX_ORDER];
  real sh_a_q[MAX_ORDER];
  real sh_b_q[MAX_ORDER];
  real sh_a_d[MAX_ORDER];
  real sh_b_d[MAX_ORDER];
  real uh_q  [MAX_ORDER];
  real yh_q  [MAX_ORDER];
  real uh_d  [MAX_ORDER];
  real yh_d  [MAX_ORDER];

  real y_raw, y_d, y_q, slice_in;
  logic sat_d, sat_q;

  eq_state_e   state_q, state_d;
  int unsigned cnt_q, cnt_d;
  int unsigned wr_idx;

  // Shadow bank update; the write is visible to a commit in the same cycle.
  always_comb begin
    sh_a_d = sh_a_q;
    sh_b_d = sh_b_q;
    wr_idx = 32'(coef_idx);
    if (coef_wr && wr_idx >= 1 && wr_idx <= ORDER) begin
      if (coef_sel) begin
        sh_a_d[wr_idx-1] = coef_data;
      end else begin
        sh_b_d[wr_idx-1] = coef_data;
      end
    end
  end

  // Filter datapath, clamp and history shift.
  // A commit edge clears the history, so its output is 0.0 rather than a
  // filtered value, matching the state a reset leaves behind.
  always_comb begin
    y_raw = 0.0;
    for (int unsigned k = 0; k < ORDER; k++) begin
      y_raw = y_raw + a_q[k] * yh_q[k] + b_q[k] * uh_q[k];
    end
    sat_d = 1'b0;
    y_d   = y_raw;
    if (y_raw > SAT_LIMIT) begin
      y_d   = SAT_LIMIT;
      sat_d = 1'b1;
    end else if (y_raw < -SAT_LIMIT) begin
      y_d   = -SAT_LIMIT;
      sat_d = 1'b1;
    end
    uh_d[0] = eq_in;
    yh_d[0] = y_d;
    for (int unsigned k = 1; k < MAX_ORDER; k++) begin
      uh_d[k] = uh_q[k-1];
      yh_d[k] = yh_q[k-1];
    end
    if (coef_commit) begin
      y_d   = 0.0;
      sat_d = 1'b0;
      for (int unsigned k = 0; k < MAX_ORDER; k++) begin
        uh_d[k] = 0.0;
        yh_d[k] = 0.0;
      end
    end
    slice_in = bypass ? eq_in : y_d;
  end

  // Warm-up / run next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (coef_commit) begin
      state_d = eq_pkg::WARMUP;
      cnt_d   = 0;
    end else if (state_q == eq_pkg::WARMUP) begin
      if (cnt_q + 1 >= WARMUP) begin
        state_d = eq_pkg::RUN;
        cnt_d   = 0;
      end else begin
        cnt_d = cnt_q + 1;
      end
    end
  end

  // State, coefficient banks, history and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= eq_pkg::WARMUP;
      cnt_q   <= 0;
      a_q     <= DEF_A;
      b_q     <= DEF_B;
      sh_a_q  <= DEF_A;
      sh_b_q  <= DEF_B;
      for (int unsigned k = 0; k < MAX_ORDER; k++) begin
        uh_q[k] <= 0.0;
        yh_q[k] <= 0.0;
      end
      y_q     <= 0.0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      if (coef_commit) begin
        a_q <= sh_a_d;
        b_q <= sh_b_d;
      end
      uh_q    <= uh_d;
      yh_q    <= yh_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
    end
  end

  eq_slicer #(
    .THRESH(THRESH),
    .HYST  (HYST)
  ) u_slicer (
    .clk    (clk),
    .rst    (rst),
    .value_i(slice_in),
    .bit_o  (eq_bit)
  );

  assign eq_y     = y_q;
  assign sat_flag = sat_q;
  assign eq_valid = (state_q == eq_pkg::RUN);

endmodule

// File: tb/tb_iir_eq_slicer.sv
// Bench for iir_eq_slicer: directed scenarios plus random traffic, checked
// against a queue-based reference model of the filter, banks and slicers.
module tb_iir_eq_slicer;

  localparam int unsigned ORDER  = 2;
  localparam int unsigned WARMUP = 2;
  localparam real THRESH = 0.49427;
  localparam real SAT    = 16.0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, bypass, coef_wr, coef_sel, coef_commit;
  logic [1:0] coef_idx;
  real        eq_in, coef_data;
  real        eq_y, eq_y2;
  logic       eq_bit, eq_valid, sat_flag;
  logic       eq_bit2, eq_valid2, sat_flag2;

  int checks = 0;
  int errors = 0;

  iir_eq_slicer #(.ORDER(ORDER), .WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .eq_in(eq_in), .bypass(bypass),
    .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_idx(coef_idx),
    .coef_data(coef_data), .coef_commit(coef_commit),
    .eq_y(eq_y), .eq_bit(eq_bit), .eq_valid(eq_valid), .sat_flag(sat_flag)
  );

  iir_eq_slicer #(.ORDER(ORDER), .WARMUP(WARMUP), .HYST(0.2)) dut_h (
    .clk(clk), .rst(rst), .eq_in(eq_in), .bypass(bypass),
    .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_idx(coef_idx),
    .coef_data(coef_data), .coef_commit(coef_commit),
    .eq_y(eq_y2), .eq_bit(eq_bit2), .eq_valid(eq_valid2), .sat_flag(sat_flag2)
  );

  // Reference model state; histories are queues with the newest sample first.
  real m_a[ORDER], m_b[ORDER], m_sa[ORDER], m_sb[ORDER];
  real m_u[$], m_yh[$];
  real m_y;
  bit  m_sat, m_bit, m_bit2;
  int  m_since;

  function automatic bit slice(real v, bit prev, real hyst);
    if (v >= THRESH + hyst / 2.0) return 1'b1;
    if (v <  THRESH - hyst / 2.0) return 1'b0;
    return prev;
  endfunction

  task automatic model_edge();
    real acc, src;
    if (rst) begin
      m_a = '{1.424, -0.5001};
      m_b = '{7.264, -7.188};
      m_sa = m_a;
      m_sb = m_b;
      m_u  = '{0.0, 0.0};
      m_yh = '{0.0, 0.0};
      m_y = 0.0; m_sat = 0; m_bit = 0; m_bit2 = 0; m_since = 0;
      return;
    end
    if (coef_wr && coef_idx >= 1 && coef_idx <= ORDER) begin
      if (coef_sel) m_sa[coef_idx-1] = coef_data;
      else          m_sb[coef_idx-1] = coef_data;
    end
    if (coef_commit) begin
      m_a = m_sa;
      m_b = m_sb;
      m_u  = '{0.0, 0.0};
      m_yh = '{0.0, 0.0};
      m_y = 0.0; m_sat = 0; m_since = 0;
    end else begin
      acc = 0.0;
      foreach (m_a[i]) acc += m_a[i] * m_yh[i] + m_b[i] * m_u[i];
      m_sat = (acc > SAT) || (acc < -SAT);
      m_y   = (acc > SAT) ? SAT : ((acc < -SAT) ? -SAT : acc);
      m_u.push_front(eq_in);  void'(m_u.pop_back());
      m_yh.push_front(m_y);   void'(m_yh.pop_back());
      m_since++;
    end
    src    = bypass ? eq_in : m_y;
    m_bit  = slice(src, m_bit, 0.0);
    m_bit2 = slice(src, m_bit2, 0.2);
  endtask

  task automatic chk_r(string tag, real obs, real exp);
    checks++;
    assert ((obs - exp) < 1.0e-6 && (exp - obs) < 1.0e-6) else begin
      errors++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  task automatic chk_b(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk_r("eq_y",      eq_y,      m_y);
    chk_b("eq_bit",    eq_bit,    m_bit);
    chk_b("eq_valid",  eq_valid,  m_since >= int'(WARMUP));
    chk_b("sat_flag",  sat_flag,  m_sat);
    chk_r("eq_y_h",    eq_y2,     m_y);
    chk_b("eq_bit_h",  eq_bit2,   m_bit2);
    chk_b("eq_valid_h", eq_valid2, m_since >= int'(WARMUP));
  endtask

  task automatic idle_inputs();
    coef_wr = 0; coef_sel = 0; coef_idx = '0; coef_data = 0.0; coef_commit = 0;
  endtask

  initial begin
    rst = 1; bypass = 0; eq_in = 0.0;
    idle_inputs();

    // Reset state
    repeat (3) step();
    chk_r("rst_eq_y", eq_y, 0.0);
    chk_b("rst_valid", eq_valid, 1'b0);
    chk_b("rst_bit", eq_bit, 1'b0);

    // Default impulse/step response
    rst = 0; eq_in = 1.0;
    step(); chk_r("dflt_e1", eq_y, 0.0);      chk_b("dflt_v1", eq_valid, 1'b0); chk_b("dflt_b1", eq_bit, 1'b0);
    step(); chk_r("dflt_e2", eq_y, 7.264);    chk_b("dflt_v2", eq_valid, 1'b1); chk_b("dflt_b2", eq_bit, 1'b1);
    step(); chk_r("dflt_e3", eq_y, 10.419936);
    repeat (3) step();

    // Out-of-range tap indices are ignored
    coef_wr = 1; coef_sel = 0; coef_idx = 2'd0; coef_data = 99.0; step();
    coef_sel = 1; coef_idx = 2'd3; step();
    idle_inputs(); coef_commit = 1; step();
    chk_b("commit_valid", eq_valid, 1'b0);
    idle_inputs();
    step(); chk_r("badidx_e1", eq_y, 0.0);
    step(); chk_r("badidx_e2", eq_y, 7.264);
    step(); chk_r("badidx_e3", eq_y, 10.419936);

    // a_1 = 2.0: unstable ramp into the clamp
    coef_wr = 1; coef_sel = 1; coef_idx = 2'd1; coef_data = 2.0; step();
    idle_inputs(); coef_commit = 1; step();
    idle_inputs();
    step(); chk_r("ramp_e1", eq_y, 0.0);
    step(); chk_r("ramp_e2", eq_y, 7.264);
    step(); chk_r("ramp_e3", eq_y, 14.604);   chk_b("ramp_s3", sat_flag, 1'b0);
    step(); chk_r("ramp_e4", eq_y, 16.0);     chk_b("ramp_s4", sat_flag, 1'b1);
    step(); chk_r("ramp_e5", eq_y, 16.0);     chk_b("ramp_s5", sat_flag, 1'b1);
    repeat (2) step();

    // Back-to-back commits restart warm-up
    coef_commit = 1; step();
    step();
    coef_commit = 0;
    step(); chk_b("dbl_v1", eq_valid, 1'b0); chk_r("dbl_y1", eq_y, 0.0);
    step(); chk_b("dbl_v2", eq_valid, 1'b1);

    // Write and commit in the same cycle: restores a_1 default
    coef_wr = 1; coef_sel = 1; coef_idx = 2'd1; coef_data = 1.424; coef_commit = 1; step();
    idle_inputs();
    step(); step(); chk_r("wrcm_e2", eq_y, 7.264);
    step(); chk_r("wrcm_e3", eq_y, 10.419936);

    // Reset with a pending shadow write loses the write
    coef_wr = 1; coef_sel = 0; coef_idx = 2'd1; coef_data = 5.0; step();
    coef_data = 3.0; rst = 1; step();
    chk_r("rstp_y", eq_y, 0.0); chk_b("rstp_sat", sat_flag, 1'b0); chk_b("rstp_bit", eq_bit, 1'b0);
    rst = 0; idle_inputs(); coef_commit = 1; step();
    idle_inputs();
    step(); step(); chk_r("rstp_e2", eq_y, 7.264);

    // Bypass slicing through the hysteresis band
    bypass = 1; eq_in = 0.0; step();
    eq_in = 0.50; step(); chk_b("hyst_050", eq_bit2, 1'b0);
    eq_in = 0.58; step(); chk_b("hyst_058", eq_bit2, 1'b0); chk_b("nohyst_058", eq_bit, 1'b1);
    eq_in = 0.62; step(); chk_b("hyst_062", eq_bit2, 1'b1);
    eq_in = 0.45; step(); chk_b("hyst_045", eq_bit2, 1'b1); chk_b("nohyst_045", eq_bit, 1'b0);
    eq_in = 0.38; step(); chk_b("hyst_038", eq_bit2, 1'b0);

    // Random traffic: samples, bypass toggles, tap writes and commits
    for (int n = 0; n < 120; n++) begin
      eq_in       = real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0;
      bypass      = ($urandom_range(0, 3) == 0);
      coef_wr     = ($urandom_range(0, 3) == 0);
      coef_sel    = $urandom_range(0, 1);
      coef_idx    = 2'($urandom_range(0, 3));
      coef_data   = real'(int'($urandom_range(0, 2000)) - 1000) / 1000.0;
      coef_commit = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
